// File: rtl/prbs_link_test_sequencer.sv
// PRBS7 single-lane BER test sequencer: free-running generator, self-synchronising checker, LOCK/RUN/DRAIN control.
// Optional first-error capture outputs are built only when PRBS_LINK_TEST_FIRST_ERR_EN is defined.
module prbs_link_test_sequencer #(
    parameter int LOCK_LEN     = 32,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int DRAIN_LEN    = 16,
    parameter int COUNT_W      = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] test_length,
    output logic               tx_data,
    input  logic               rx_data,
    output logic               inject_stop,
    output logic               busy,
    output logic               done,
    output logic               lock_fail,
    output logic [COUNT_W-1:0] bit_count,
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
    output logic               first_err_valid,
    output logic [COUNT_W-1:0] first_err_index,
`endif
    output logic [COUNT_W-1:0] error_count
);

    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_LEN + 1);
    localparam logic [MW-1:0] LOCK_LEN_C   = MW'(LOCK_LEN);
    localparam logic [TW-1:0] TIMEOUT_C    = TW'(LOCK_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_LAST_C = DW'(DRAIN_LEN - 1);
    localparam logic [6:0]    GEN_SEED     = 7'h7F;
    localparam logic [2:0]    SEED_LEN     = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_LOCK, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [6:0]         gen_q, gen_d;
    logic               tx_q, tx_d;
    logic [6:0]         rs_q, rs_d;
    logic               lock_fail_q, lock_fail_d;
    logic [COUNT_W-1:0] bit_q, bit_d;
    logic [COUNT_W-1:0] err_q, err_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic [2:0]         seed_q, seed_d;
    logic [MW-1:0]      match_q, match_d;
    logic [TW-1:0]      lock_cyc_q, lock_cyc_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               gen_bit, expected, mismatch, accept;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
    logic               fe_vld_q, fe_vld_d;
    logic [COUNT_W-1:0] fe_idx_q, fe_idx_d;
`endif

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v, input logic inc);
        logic [COUNT_W-1:0] r;
        r = v;
        if (inc && (v != '1)) r = v + 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        lock_fail_d = lock_fail_q;
        bit_d       = bit_q;
        err_d       = err_q;
        len_d       = len_q;
        seed_d      = seed_q;
        match_d     = match_q;
        lock_cyc_d  = lock_cyc_q;
        drain_d     = drain_q;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
        fe_vld_d    = fe_vld_q;
        fe_idx_d    = fe_idx_q;
`endif
        gen_bit  = gen_q[6] ^ gen_q[5];
        gen_d    = {gen_q[5:0], gen_bit};
        tx_d     = gen_bit;
        expected = rs_q[6] ^ rs_q[5];
        mismatch = (rx_data != expected);
        accept   = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d     = S_LOCK;
                    bit_d       = '0;
                    err_d       = '0;
                    lock_fail_d = 1'b0;
                    rs_d        = '0;
                    seed_d      = '0;
                    match_d     = '0;
                    lock_cyc_d  = '0;
                    len_d       = test_length;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
                    fe_vld_d    = 1'b0;
                    fe_idx_d    = '0;
`endif
                end
            end
            S_LOCK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rs_d       = {rs_q[5:0], rx_data};
                    lock_cyc_d = lock_cyc_q + 1'b1;
                    // An all-zero register predicts zeros forever, so it never counts toward lock.
                    if (seed_q != SEED_LEN) seed_d = seed_q + 1'b1;
                    else if (!mismatch && (rs_q != '0)) match_d = match_q + 1'b1;
                    else match_d = '0;
                    drain_d = '0;
                    if (match_d == LOCK_LEN_C) begin
                        state_d = (len_q == '0) ? S_DRAIN : S_RUN;
                    end else if (lock_cyc_d == TIMEOUT_C) begin
                        lock_fail_d = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // Flywheel: feed back the prediction so a single flipped bit cannot propagate.
                    rs_d  = {rs_q[5:0], expected};
                    bit_d = bit_q + 1'b1;
                    err_d = sat_inc(err_q, mismatch);
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
                    if (mismatch && !fe_vld_q) begin
                        fe_vld_d = 1'b1;
                        fe_idx_d = bit_q;
                    end
`endif
                    drain_d = '0;
                    if (bit_d == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                    if (drain_q == DRAIN_LAST_C) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            gen_q       <= GEN_SEED;
            tx_q        <= 1'b0;
            rs_q        <= '0;
            lock_fail_q <= 1'b0;
            bit_q       <= '0;
            err_q       <= '0;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
            fe_vld_q    <= 1'b0;
            fe_idx_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gen_q       <= gen_d;
            tx_q        <= tx_d;
            rs_q        <= rs_d;
            lock_fail_q <= lock_fail_d;
            bit_q       <= bit_d;
            err_q       <= err_d;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
            fe_vld_q    <= fe_vld_d;
            fe_idx_q    <= fe_idx_d;
`endif
        end
    end

    // Working counters are always initialised on an accepted start, so they carry no reset.
    always_ff @(posedge clock) begin
        len_q      <= len_d;
        seed_q     <= seed_d;
        match_q    <= match_d;
        lock_cyc_q <= lock_cyc_d;
        drain_q    <= drain_d;
    end

    assign tx_data     = tx_q;
    assign inject_stop = (state_q != S_RUN);
    assign busy        = (state_q == S_LOCK) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign lock_fail   = lock_fail_q;
    assign bit_count   = bit_q;
    assign error_count = err_q;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
    assign first_err_valid = fe_vld_q;
    assign first_err_index = fe_idx_q;
`endif

endmodule

// File: tb/tb_prbs_link_test_sequencer.sv
// Randomised bench for prbs_link_test_sequencer: loopback lane with selectable delay and gated bit flips,
// checked against window lengths and error totals derived directly from the test rules.
module tb_prbs_link_test_sequencer;

    localparam int LOCK_LEN     = 32;
    localparam int LOCK_TIMEOUT = 1024;
    localparam int DRAIN_LEN    = 16;
    localparam int COUNT_W      = 64;

    logic               clock = 1'b0;
    logic               reset_n, start, abort, rx_data;
    logic [COUNT_W-1:0] test_length;
    logic               tx_data, inject_stop, busy, done, lock_fail;
    logic [COUNT_W-1:0] bit_count, error_count;
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
    logic               first_err_valid;
    logic [COUNT_W-1:0] first_err_index;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   dly_sel  = 0;
    logic force_zero = 1'b0;
    logic flip = 1'b0;
    logic [7:0] dly_line = '0;
    logic lane_bit;
    logic flip_map [0:1023];

    always #5 clock = ~clock;
    always @(posedge clock) dly_line <= {dly_line[6:0], tx_data};
    assign lane_bit = (dly_sel == 0) ? tx_data : dly_line[dly_sel-1];
    assign rx_data  = force_zero ? 1'b0 : (lane_bit ^ flip);

    prbs_link_test_sequencer #(
        .LOCK_LEN(LOCK_LEN), .LOCK_TIMEOUT(LOCK_TIMEOUT), .DRAIN_LEN(DRAIN_LEN), .COUNT_W(COUNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .test_length(test_length), .tx_data(tx_data), .rx_data(rx_data),
        .inject_stop(inject_stop), .busy(busy), .done(done), .lock_fail(lock_fail),
        .bit_count(bit_count),
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
        .first_err_valid(first_err_valid), .first_err_index(first_err_index),
`endif
        .error_count(error_count)
    );

    task automatic chk(input string tag, input logic [COUNT_W-1:0] got, input logic [COUNT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".tx"}, 64'(tx_data), 64'd0);
        chk({tag, ".inject_stop"}, 64'(inject_stop), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".lock_fail"}, 64'(lock_fail), 64'd0);
        chk({tag, ".bits"}, bit_count, 64'd0);
        chk({tag, ".errs"}, error_count, 64'd0);
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
        chk({tag, ".fe_valid"}, 64'(first_err_valid), 64'd0);
`endif
    endtask

    // One complete test; the model is the set of flipped RUN indices plus the expected window lengths.
    task automatic run_test(input string name, input int dly, input int len, input int nfl,
                            input int fixed_flip, input bit zero_lane, input bit extra_start);
        int pre, run, post, nerr, first_idx, lock_cycles, exp_run, idx;
        bit reached;
        for (int i = 0; i < 1024; i++) flip_map[i] = 1'b0;
        nerr = 0;
        first_idx = -1;
        if (fixed_flip >= 0 && fixed_flip < len) begin
            flip_map[fixed_flip] = 1'b1;
            nerr = 1;
            first_idx = fixed_flip;
        end
        for (int k = 0; k < nfl && nerr < len; k++) begin
            idx = int'($urandom_range(0, len - 1));
            if (!flip_map[idx]) begin
                flip_map[idx] = 1'b1;
                nerr++;
                if (first_idx < 0 || idx < first_idx) first_idx = idx;
            end
        end
        dly_sel = dly;
        force_zero = zero_lane;
        repeat (12) @(negedge clock);
        test_length = COUNT_W'(len);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pre = 0; run = 0; post = 0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                reached = 1'b1;
                break;
            end
            if (!inject_stop) run++;
            else if (busy) begin
                if (run == 0) pre++;
                else post++;
            end
            start = extra_start && !inject_stop && (bit_count == 64'd1);
            flip  = !inject_stop && (bit_count < 64'd1024) && flip_map[bit_count[9:0]];
            @(negedge clock);
        end
        flip = 1'b0;
        start = 1'b0;
        chk({name, ".done_reached"}, 64'(reached), 64'd1);
        lock_cycles = zero_lane ? LOCK_TIMEOUT : 7 + LOCK_LEN;
        exp_run = zero_lane ? 0 : len;
        chk({name, ".lock_window"}, 64'(pre), 64'(exp_run == 0 ? lock_cycles + DRAIN_LEN : lock_cycles));
        chk({name, ".run_window"}, 64'(run), 64'(exp_run));
        chk({name, ".drain_window"}, 64'(post), 64'(exp_run == 0 ? 0 : DRAIN_LEN));
        chk({name, ".bits"}, bit_count, 64'(exp_run));
        chk({name, ".errs"}, error_count, 64'(zero_lane ? 0 : nerr));
        chk({name, ".lock_fail"}, 64'(lock_fail), 64'(zero_lane));
`ifdef PRBS_LINK_TEST_FIRST_ERR_EN
        chk({name, ".fe_valid"}, 64'(first_err_valid), 64'(!zero_lane && nerr > 0));
        if (!zero_lane && nerr > 0) chk({name, ".fe_index"}, first_err_index, 64'(first_idx));
`endif
        repeat (3) @(negedge clock);
        chk({name, ".done_hold"}, 64'(done), 64'd1);
        chk({name, ".idle_busy"}, 64'(busy), 64'd0);
        force_zero = 1'b0;
    endtask

    // Start a test and run until the RUN window reaches the given bit index.
    task automatic start_and_reach(input string name, input int len, input int at_bit);
        bit hit;
        dly_sel = 2;
        repeat (12) @(negedge clock);
        test_length = COUNT_W'(len);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!inject_stop && bit_count == 64'(at_bit)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk({name, ".reached_bit"}, 64'(hit), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        test_length = '0;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_start.busy", 64'(busy), 64'd0);

        run_test("direct", 0, 1000, 0, -1, 1'b0, 1'b0);
        run_test("dly5", 5, 500, 0, -1, 1'b0, 1'b0);
        run_test("flip100", 5, 500, 0, 100, 1'b0, 1'b0);
        run_test("zero_lane", 0, 300, 0, -1, 1'b1, 1'b0);
        run_test("len0", 3, 0, 0, -1, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            run_test($sformatf("rand%0d", t), int'($urandom_range(0, 6)), int'($urandom_range(1, 400)),
                     int'($urandom_range(0, 4)), -1, 1'b0, 1'($urandom_range(0, 1)));
        end

        start_and_reach("abort", 1000, 200);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.inject_stop", 64'(inject_stop), 64'd1);
        chk("abort.bits", bit_count, 64'd200);
        repeat (5) @(negedge clock);
        chk("abort.no_restart", 64'(busy), 64'd0);
        chk("abort.bits_held", bit_count, 64'd200);

        start_and_reach("midreset", 1000, 50);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk_reset_vals("midreset");
        repeat (20) @(negedge clock);
        run_test("after_reset", 1, 120, 2, -1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
